// File: rtl/simd_lane_pipe.sv
// Two-stage SIMD lane: S1 reads operands (with S2 bypass) and executes, S2 holds the
// registered result and performs the register-file writeback on handshake.
module simd_lane_pipe #(
  parameter int DATA_W    = 16,
  parameter int REG_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wb_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_rd,
  output logic              res_ovf
);

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_BITREV  = 3'b010,
    OP_MUL     = 3'b011,
    OP_MAC     = 3'b100,
    OP_ACC_CLR = 3'b101,
    OP_RSV6    = 3'b110,
    OP_RSV7    = 3'b111
  } opcode_t;

  logic [DATA_W-1:0] regfile [REG_DEPTH];

  logic              s1_valid;
  opcode_t           s1_op;
  logic [ADDR_W-1:0] s1_rs1;
  logic [ADDR_W-1:0] s1_rs2;
  logic [ADDR_W-1:0] s1_rd;
  logic              s1_wb;

  logic              res_wb;
  logic [DATA_W-1:0] acc;

  logic              stall;
  logic              accept;
  logic              wb_fire;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [2*DATA_W-1:0] prod;

  logic [DATA_W-1:0] ex_data;
  logic              ex_ovf;
  logic              ex_wb;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W:0]   sum_w;

  assign stall    = res_valid && !res_ready;
  assign op_ready = !stall;
  assign accept   = op_valid && op_ready;
  assign wb_fire  = res_valid && res_ready && res_wb;

  // S2 forwarding stays live during a stall since S2 has not written back yet.
  always_comb begin
    op_a = regfile[s1_rs1];
    op_b = regfile[s1_rs2];
    if (res_valid && res_wb && (res_rd == s1_rs1)) op_a = res_data;
    if (res_valid && res_wb && (res_rd == s1_rs2)) op_b = res_data;
  end

  assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

  always_comb begin
    ex_data = '0;
    ex_ovf  = 1'b0;
    ex_wb   = s1_wb;
    acc_nxt = acc;
    sum_w   = '0;
    case (s1_op)
      OP_ADD: begin
        sum_w   = {1'b0, op_a} + {1'b0, op_b};
        ex_data = sum_w[DATA_W-1:0];
        ex_ovf  = sum_w[DATA_W];
      end
      OP_SUB: begin
        ex_data = op_a - op_b;
        ex_ovf  = (op_a < op_b);
      end
      OP_BITREV: begin
        for (int unsigned i = 0; i < DATA_W; i++) ex_data[i] = op_a[DATA_W-1-i];
      end
      OP_MUL: begin
        ex_data = prod[DATA_W-1:0];
        ex_ovf  = |prod[2*DATA_W-1:DATA_W];
      end
      OP_MAC: begin
        sum_w   = {1'b0, acc} + {1'b0, prod[DATA_W-1:0]};
        ex_data = sum_w[DATA_W-1:0];
        ex_ovf  = sum_w[DATA_W] | (|prod[2*DATA_W-1:DATA_W]);
        acc_nxt = sum_w[DATA_W-1:0];
      end
      OP_ACC_CLR: begin
        acc_nxt = '0;
      end
      default: begin
        ex_wb = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regfile[i] <= '0;
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_rd     <= '0;
      s1_wb     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_ovf   <= 1'b0;
      res_wb    <= 1'b0;
      acc       <= '0;
    end else begin
      // Pipeline writeback is issued last so it overrides an external write to the same slot.
      if (ext_wr_en) regfile[ext_wr_addr] <= ext_wr_data;
      if (wb_fire)   regfile[res_rd]      <= res_data;

      if (!stall) begin
        s1_valid <= accept;
        if (accept) begin
          s1_op  <= opcode_t'(opcode);
          s1_rs1 <= rs1;
          s1_rs2 <= rs2;
          s1_rd  <= rd;
          s1_wb  <= wb_en;
        end
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_data <= ex_data;
          res_rd   <= s1_rd;
          res_ovf  <= ex_ovf;
          res_wb   <= ex_wb;
          acc      <= acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_lane_pipe.sv
// Directed bench for simd_lane_pipe: latency, bypass, arithmetic flags, accumulator,
// back-pressure, write collisions and reset behaviour, all against hand-computed values.
module tb_simd_lane_pipe;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ext_wr_en;
  logic [AW-1:0] ext_wr_addr;
  logic [DW-1:0] ext_wr_data;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    opcode;
  logic [AW-1:0] rs1, rs2, rd;
  logic          wb_en;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_rd;
  logic          res_ovf;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, BREV = 3'b010, MUL = 3'b011,
                         MAC = 3'b100, CLR = 3'b101, RSV = 3'b111;

  simd_lane_pipe #(.DATA_W(DW), .REG_DEPTH(32), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wb_en(wb_en),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
    tick();
    ext_wr_en = 1'b0;
  endtask

  // Issues one op, waits (bounded) for its result, then lets it drain; X on timeout.
  task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] d, input logic w,
                        output logic [DW-1:0] data, output logic ovf, output logic [AW-1:0] rdo);
    data = 'x; ovf = 1'bx; rdo = 'x;
    opcode = op; rs1 = a; rs2 = b; rd = d; wb_en = w; op_valid = 1'b1;
    tick();
    op_valid = 1'b0; ext_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid) begin
        data = res_data; ovf = res_ovf; rdo = res_rd;
        break;
      end
    end
    tick();
  endtask

  task automatic read_reg(input logic [AW-1:0] a, output logic [DW-1:0] v);
    logic o; logic [AW-1:0] r;
    run_op(ADD, a, 5'd0, 5'd0, 1'b0, v, o, r);
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    rst = 1'b0; res_ready = 1'b1;
    op_valid = 1'b1; opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; wb_en = 1'b1;
    ext_wr_en = 1'b1; ext_wr_addr = 5'd5; ext_wr_data = 16'h1234;
    repeat (3) tick();
    total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %h want 0", res_valid); else passed++;
    total++; if (res_data !== 16'h0000) $display("FAIL rst_res_data got %h want 0000", res_data); else passed++;
    total++; if (res_rd !== 5'd0) $display("FAIL rst_res_rd got %h want 00", res_rd); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL rst_res_ovf got %h want 0", res_ovf); else passed++;
    op_valid = 1'b0; ext_wr_en = 1'b0; rst = 1'b1;
    tick();
    total++; if (op_ready !== 1'b1) $display("FAIL rst_op_ready got %h want 1", op_ready); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL rst_no_op_accepted got %h want 0", res_valid); else passed++;
    read_reg(5'd5, v);
    total++; if (v !== 16'h0000) $display("FAIL rst_ext_ignored got %h want 0000", v); else passed++;
  endtask

  task automatic test_add();
    logic [DW-1:0] v;
    ext_load(5'd1, 16'h0003);
    ext_load(5'd2, 16'h0005);
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; wb_en = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    total++; if (res_valid !== 1'b0) $display("FAIL add_lat1 got %h want 0", res_valid); else passed++;
    tick();
    total++; if (res_valid !== 1'b1) $display("FAIL add_lat2 got %h want 1", res_valid); else passed++;
    total++; if (res_data !== 16'h0008) $display("FAIL add_data got %h want 0008", res_data); else passed++;
    total++; if (res_rd !== 5'd3) $display("FAIL add_rd got %h want 03", res_rd); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL add_ovf got %h want 0", res_ovf); else passed++;
    tick();
    total++; if (res_valid !== 1'b0) $display("FAIL add_bubble got %h want 0", res_valid); else passed++;
    total++; if (res_data !== 16'h0008) $display("FAIL add_hold got %h want 0008", res_data); else passed++;
    read_reg(5'd3, v);
    total++; if (v !== 16'h0008) $display("FAIL add_wb_r3 got %h want 0008", v); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    ext_load(5'd3, 16'h0007);
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; wb_en = 1'b1; op_valid = 1'b1;
    tick();
    opcode = MUL; rs1 = 5'd3; rs2 = 5'd2; rd = 5'd4; wb_en = 1'b1;
    tick();
    op_valid = 1'b0;
    total++; if (res_data !== 16'h0008) $display("FAIL b2b_first got %h want 0008", res_data); else passed++;
    tick();
    total++; if (res_valid !== 1'b1) $display("FAIL b2b_second_valid got %h want 1", res_valid); else passed++;
    total++; if (res_data !== 16'h0028) $display("FAIL b2b_bypass got %h want 0028", res_data); else passed++;
    total++; if (res_rd !== 5'd4) $display("FAIL b2b_rd got %h want 04", res_rd); else passed++;
    total++; if (res_ovf !== 1'b0) $display("FAIL b2b_ovf got %h want 0", res_ovf); else passed++;
    tick();
    read_reg(5'd4, v);
    total++; if (v !== 16'h0028) $display("FAIL b2b_wb_r4 got %h want 0028", v); else passed++;
  endtask

  task automatic test_arith();
    logic [DW-1:0] d; logic o; logic [AW-1:0] r;
    run_op(SUB, 5'd1, 5'd2, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'hFFFE || o !== 1'b1) $display("FAIL sub got %h/%h want FFFE/1", d, o); else passed++;
    ext_load(5'd6, 16'h0001);
    run_op(BREV, 5'd6, 5'd2, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h8000 || o !== 1'b0) $display("FAIL bitrev got %h/%h want 8000/0", d, o); else passed++;
    ext_load(5'd7, 16'h0100);
    run_op(MUL, 5'd7, 5'd7, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h0000 || o !== 1'b1) $display("FAIL mul_ovf got %h/%h want 0000/1", d, o); else passed++;
    ext_load(5'd8, 16'hFFFF);
    run_op(ADD, 5'd8, 5'd1, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h0002 || o !== 1'b1) $display("FAIL add_carry got %h/%h want 0002/1", d, o); else passed++;
    ext_load(5'd9, 16'h1234);
    run_op(RSV, 5'd1, 5'd2, 5'd9, 1'b1, d, o, r);
    total++; if (d !== 16'h0000 || o !== 1'b0) $display("FAIL reserved got %h/%h want 0000/0", d, o); else passed++;
    read_reg(5'd9, d);
    total++; if (d !== 16'h1234) $display("FAIL reserved_no_wb got %h want 1234", d); else passed++;
  endtask

  task automatic test_ext_write();
    logic [DW-1:0] v; logic o; logic [AW-1:0] r;
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd15; wb_en = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    ext_load(5'd15, 16'hAAAA);
    read_reg(5'd15, v);
    total++; if (v !== 16'h0008) $display("FAIL ext_collide got %h want 0008", v); else passed++;
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd20; wb_en = 1'b1; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    tick();
    ext_load(5'd16, 16'hBBBB);
    read_reg(5'd20, v);
    total++; if (v !== 16'h0008) $display("FAIL ext_diff_pipe got %h want 0008", v); else passed++;
    read_reg(5'd16, v);
    total++; if (v !== 16'hBBBB) $display("FAIL ext_diff_ext got %h want BBBB", v); else passed++;
    ext_wr_en = 1'b1; ext_wr_addr = 5'd17; ext_wr_data = 16'h0011;
    run_op(ADD, 5'd17, 5'd0, 5'd0, 1'b0, v, o, r);
    total++; if (v !== 16'h0011) $display("FAIL ext_visible_next got %h want 0011", v); else passed++;
  endtask

  task automatic test_stall();
    logic [DW-1:0] v;
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd12; wb_en = 1'b1; op_valid = 1'b1;
    tick();
    opcode = SUB; rs1 = 5'd12; rs2 = 5'd1; rd = 5'd13; wb_en = 1'b1;
    tick();
    op_valid = 1'b0; res_ready = 1'b0;
    #1;
    total++; if (op_ready !== 1'b0) $display("FAIL stall_op_ready got %h want 0", op_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (res_valid !== 1'b1 || res_data !== 16'h0008 || op_ready !== 1'b0)
        $display("FAIL stall_hold cyc %0d got %h/%h/%h want 1/0008/0", i, res_valid, res_data, op_ready);
      else passed++;
    end
    res_ready = 1'b1;
    tick();
    total++; if (res_valid !== 1'b1 || res_data !== 16'h0005 || res_rd !== 5'd13)
      $display("FAIL stall_second got %h/%h/%h want 1/0005/0d", res_valid, res_data, res_rd);
    else passed++;
    tick();
    total++; if (res_valid !== 1'b0) $display("FAIL stall_drain got %h want 0", res_valid); else passed++;
    read_reg(5'd12, v);
    total++; if (v !== 16'h0008) $display("FAIL stall_wb_r12 got %h want 0008", v); else passed++;
    read_reg(5'd13, v);
    total++; if (v !== 16'h0005) $display("FAIL stall_wb_r13 got %h want 0005", v); else passed++;
  endtask

  task automatic test_mac();
    logic [DW-1:0] d; logic o; logic [AW-1:0] r;
    run_op(CLR, 5'd0, 5'd0, 5'd0, 1'b0, d, o, r);
    run_op(MAC, 5'd8, 5'd6, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'hFFFF || o !== 1'b0) $display("FAIL mac_nocarry got %h/%h want FFFF/0", d, o); else passed++;
    run_op(MAC, 5'd6, 5'd6, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h0000 || o !== 1'b1) $display("FAIL mac_carry got %h/%h want 0000/1", d, o); else passed++;
    run_op(CLR, 5'd0, 5'd0, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h0000 || o !== 1'b0) $display("FAIL acc_clr got %h/%h want 0000/0", d, o); else passed++;
    run_op(MAC, 5'd1, 5'd2, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h000F) $display("FAIL mac1 got %h want 000F", d); else passed++;
    run_op(RSV, 5'd1, 5'd2, 5'd0, 1'b0, d, o, r);
    run_op(MAC, 5'd1, 5'd2, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h001E) $display("FAIL mac2 got %h want 001E", d); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] d; logic o; logic [AW-1:0] r;
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd18; wb_en = 1'b1; op_valid = 1'b1;
    tick();
    opcode = ADD; rs1 = 5'd1; rs2 = 5'd1; rd = 5'd19;
    tick();
    op_valid = 1'b0; rst = 1'b0;
    tick();
    total++; if (res_valid !== 1'b0 || res_data !== 16'h0000 || res_rd !== 5'd0 || res_ovf !== 1'b0)
      $display("FAIL midrst_outputs got %h/%h/%h/%h want 0/0000/00/0", res_valid, res_data, res_rd, res_ovf);
    else passed++;
    rst = 1'b1;
    tick();
    total++; if (res_valid !== 1'b0 || op_ready !== 1'b1)
      $display("FAIL midrst_flushed got %h/%h want 0/1", res_valid, op_ready);
    else passed++;
    read_reg(5'd18, d);
    total++; if (d !== 16'h0000) $display("FAIL midrst_no_wb_r18 got %h want 0000", d); else passed++;
    read_reg(5'd1, d);
    total++; if (d !== 16'h0000) $display("FAIL midrst_regs_clr got %h want 0000", d); else passed++;
    ext_load(5'd1, 16'h0003);
    ext_load(5'd2, 16'h0005);
    run_op(MAC, 5'd1, 5'd2, 5'd0, 1'b0, d, o, r);
    total++; if (d !== 16'h000F) $display("FAIL midrst_acc_clr got %h want 000F", d); else passed++;
  endtask

  initial begin
    ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0;
    op_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0; wb_en = 1'b0;
    res_ready = 1'b1; rst = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_arith();
    test_ext_write();
    test_stall();
    test_mac();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simd_lane_pipe.md
SIMD_LANE_PIPE -- requirements
Module: simd_lane_pipe

Interface
REQ-001 Parameter DATA_W, 16, lane data width in bits (>=4).
REQ-002 Parameter REG_DEPTH, 32, number of lane registers.
REQ-003 Parameter ADDR_W, 5, register address width; SHALL equal clog2(REG_DEPTH).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 ext_wr_en / ext_wr_addr / ext_wr_data  in  1 / ADDR_W / DATA_W  external register load port.
REQ-007 op_valid  in  1  operation offered this cycle.
REQ-008 op_ready  out  1  lane can accept an operation this cycle.
REQ-009 opcode  in  3  000 ADD, 001 SUB, 010 BITREV, 011 MUL, 100 MAC, 101 ACC_CLR, 110/111 reserved.
REQ-010 rs1, rs2, rd  in  ADDR_W each  source and destination register addresses.
REQ-011 wb_en  in  1  write result into rd on completion.
REQ-012 res_valid  out  1  result present; res_ready  in  1  consumer accepts result.
REQ-013 res_data  out  DATA_W  result; res_rd  out  ADDR_W  destination of result; res_ovf  out  1  overflow flag.

Function
REQ-014 Accept SHALL occur on an edge where op_valid && op_ready; opcode, rs1, rs2, rd, wb_en are captured into stage S1.
REQ-015 stall = res_valid && !res_ready; op_ready SHALL equal !stall; while stalled, S1, S2, the accumulator, and all outputs hold.
REQ-016 While not stalled, S1 reads operands, executes, and SHALL register the result into S2 on the next edge; res_valid rises exactly 2 edges after accept, and back-to-back issue gives one result per cycle.
REQ-017 An empty S1 advancing SHALL clear res_valid (bubble); res_data then holds its last value.
REQ-018 ADD: rs1+rs2 mod 2^DATA_W; res_ovf is the unsigned carry-out.
REQ-019 SUB: rs1-rs2 mod 2^DATA_W; res_ovf is the borrow (rs1<rs2 unsigned).
REQ-020 BITREV: bit i of rs1 moves to bit DATA_W-1-i; rs2 is ignored; res_ovf=0.
REQ-021 MUL: low DATA_W bits of the unsigned product; res_ovf=1 if the high DATA_W bits are nonzero.
REQ-022 MAC: acc <= acc + low(rs1*rs2) mod 2^DATA_W; result is the new acc; res_ovf = carry of that addition OR product high bits nonzero.
REQ-023 ACC_CLR: acc <= 0; result 0; res_ovf=0.
REQ-024 The accumulator SHALL update only when its op moves S1->S2.
REQ-025 Reserved opcodes: result 0, res_ovf=0, no writeback, acc unchanged.
REQ-026 Writeback: on an edge with res_valid && res_ready && captured wb_en, regfile[res_rd] <= res_data, written exactly once.
REQ-027 Bypass: if S2 holds a wb op and its rd equals S1's rs1 or rs2, S1 SHALL use S2's res_data for that operand, including while stalled.
REQ-028 ext_wr writes regfile[ext_wr_addr] on the edge. If it coincides with a pipeline writeback to the same address, the pipeline writeback wins. For different addresses, both writes occur.
REQ-029 External writes have no bypass; S1 sees them from the cycle after the edge.

Reset
REQ-030 With rst=0 at an edge, the block SHALL set: res_valid=0, res_data=0, res_rd=0, res_ovf=0, acc=0, S1 empty, all registers 0; op_ready=1 after release.
REQ-031 Reset mid-operation SHALL discard in-flight ops with no writeback; ext_wr and op_valid are ignored during reset.

Verification
REQ-032 Load r1=0x0003, r2=0x0005; ADD rd=3 wb=1 -> res_data=0x0008 two edges after accept, ovf=0; then r3=0x0008.
REQ-033 ADD r1,r2->r3 wb, immediately MUL r3,r2 -> second result 0x0028 via bypass, one cycle after the first.
REQ-034 SUB r1-r2 -> 0xFFFE, ovf=1; BITREV of 0x0001 -> 0x8000; MUL 0x0100*0x0100 -> 0x0000, ovf=1.
REQ-035 ACC_CLR, then MAC(3,5) twice -> results 0x0000, 0x000F, 0x001E.
REQ-036 Hold res_ready=0 for 3 cycles with 2 ops in flight -> op_ready=0, res_data stable; on release, each result is delivered once and each wb is performed once.
REQ-037 Assert rst with 2 ops in flight and acc=0x001E -> next cycle res_valid=0, acc=0, registers 0, no writeback.
